// File: rtl/prediction_sequencer_pkg.sv
// Shared types for the prediction sequencer: FSM state encoding and digit width.
package pred_pkg;
  localparam int STATE_W = 2;
  localparam int DIGIT_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/prediction_sequencer_if.sv
// Activation memory read bus: the sequencer drives strobe/address, memory returns data one cycle later.
interface prediction_sequencer_if #(
  parameter int RESOLUTION = 8
);
  logic                  act_rd_en;
  logic [3:0]            act_addr;
  logic [RESOLUTION-1:0] act_rdata;

  modport master (output act_rd_en, output act_addr, input act_rdata);
  modport slave  (input act_rd_en, input act_addr, output act_rdata);
endinterface

// File: rtl/prediction_sequencer_argmax.sv
// Running argmax; the outputs already include the current data beat so the final beat needs no extra cycle.
module argmax_accum
  import pred_pkg::*;
#(
  parameter int RESOLUTION = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [RESOLUTION-1:0] data,
  input  logic [DIGIT_W-1:0]    idx,
  output logic [RESOLUTION-1:0] max,
  output logic [DIGIT_W-1:0]    max_idx
);

  logic [RESOLUTION-1:0] max_q;
  logic [DIGIT_W-1:0]    idx_q;
  logic                  take;

  // >= so that equal activations hand the win to the later (higher) index
  assign take = valid && (data >= max_q);

  always_comb begin
    max     = take ? data : max_q;
    max_idx = take ? idx  : idx_q;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max;
      idx_q <= max_idx;
    end
  end

endmodule

// File: rtl/prediction_sequencer.sv
// Scans NEURON_NUMBER activations and reports the argmax digit.
// Define PRED_THRESHOLD_EN to add the registered low_confidence output.
module prediction_sequencer
  import pred_pkg::*;
#(
  parameter int                    NEURON_NUMBER = 10,
  parameter int                    RESOLUTION    = 8,
  parameter logic [RESOLUTION-1:0] THRESHOLD     = 8'd64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  prediction_sequencer_if.master    act,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W-1:0]        predicted_digit,
`ifdef PRED_THRESHOLD_EN
  output logic                      low_confidence,
`endif
  output logic [RESOLUTION-1:0]     max_activation
);

  localparam logic [DIGIT_W-1:0] LAST_ADDR = DIGIT_W'(NEURON_NUMBER - 1);

  state_t                state, state_next;
  logic                  rd_en;
  logic                  scan_entry;
  logic                  scan_complete;
  logic [DIGIT_W-1:0]    addr_q;
  logic [DIGIT_W-1:0]    data_idx_q;
  logic                  data_valid_q;
  logic [RESOLUTION-1:0] acc_max;
  logic [DIGIT_W-1:0]    acc_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    busy          = 1'b1;
    done          = 1'b0;
    rd_en         = 1'b0;
    scan_entry    = 1'b0;
    scan_complete = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = READ;
          scan_entry = 1'b1;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (abort)                   state_next = IDLE;
        else if (addr_q == LAST_ADDR) state_next = DRAIN;
      end
      DRAIN: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          state_next    = DONE;
          scan_complete = 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign act.act_rd_en = rd_en;
  assign act.act_addr  = rd_en ? addr_q : '0;

  // Address walks only while staying in READ; any exit rewinds it for the next scan
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      data_valid_q <= 1'b0;
      data_idx_q   <= '0;
    end else begin
      if (state == READ && state_next == READ) addr_q <= addr_q + DIGIT_W'(1);
      else                                     addr_q <= '0;
      data_valid_q <= rd_en;
      data_idx_q   <= addr_q;
    end
  end

  argmax_accum #(.RESOLUTION(RESOLUTION)) u_argmax (
    .clk     (clk),
    .reset   (reset),
    .clear   (scan_entry),
    .valid   (data_valid_q),
    .data    (act.act_rdata),
    .idx     (data_idx_q),
    .max     (acc_max),
    .max_idx (acc_idx)
  );

  // Results load on the DRAIN->DONE edge, i.e. the same edge that raises done
  always_ff @(posedge clk) begin
    if (reset) begin
      predicted_digit <= '0;
      max_activation  <= '0;
`ifdef PRED_THRESHOLD_EN
      low_confidence  <= 1'b0;
`endif
    end else if (scan_complete) begin
      predicted_digit <= acc_idx;
      max_activation  <= acc_max;
`ifdef PRED_THRESHOLD_EN
      low_confidence  <= (acc_max < THRESHOLD);
`endif
    end
  end

endmodule

// File: tb/tb_prediction_sequencer.sv
// Directed bench for prediction_sequencer with a one-cycle-latency activation memory model.
module tb_prediction_sequencer;
  import pred_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] predicted_digit;
  logic [7:0] max_activation;
`ifdef PRED_THRESHOLD_EN
  logic       low_confidence;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];

  int         first_done, second_done, pulses;
  logic [3:0] dig_at_done;
  logic [7:0] max_at_done;

  localparam logic [79:0] VEC_A    = {8'd3, 8'd9, 8'd1, 8'd200, 8'd7, 8'd0, 8'd5, 8'd5, 8'd2, 8'd100};
  localparam logic [79:0] VEC_50   = {10{8'd50}};
  localparam logic [79:0] VEC_ZERO = '0;

  prediction_sequencer_if #(.RESOLUTION(8)) act_bus ();

  prediction_sequencer #(
    .NEURON_NUMBER (10),
    .RESOLUTION    (8),
    .THRESHOLD     (8'd64)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .act             (act_bus),
    .busy            (busy),
    .done            (done),
    .predicted_digit (predicted_digit),
`ifdef PRED_THRESHOLD_EN
    .low_confidence  (low_confidence),
`endif
    .max_activation  (max_activation)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (act_bus.act_rd_en) act_bus.act_rdata <= mem[act_bus.act_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic loadMem(input logic [79:0] v);
    for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? v[(9 - i) * 8 +: 8] : 8'd0;
  endtask

  task automatic checkResult(input string tag, input int digit, input int maxv, input int low);
    checkOutput({tag, "_digit"}, predicted_digit, digit);
    checkOutput({tag, "_max"}, max_activation, maxv);
`ifdef PRED_THRESHOLD_EN
    checkOutput({tag, "_lowconf"}, low_confidence, low);
`else
    if (low < 0) checkOutput({tag, "_lowconf"}, 0, 1);
`endif
  endtask

  // Cycle n is the n-th cycle after the one in which start was high
  task automatic applyStimulus(input int abort_at, input int restart_at, input int reset_at,
                               input bit abort_with_start, input bit check_addr,
                               output int fd, output int sd, output int np,
                               output logic [3:0] dd, output logic [7:0] md);
    fd = 0; sd = 0; np = 0; dd = '0; md = '0;
    start = 1'b1;
    abort = abort_with_start;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (done) begin
        np++;
        if (np == 1) begin
          fd = n;
          dd = predicted_digit;
          md = max_activation;
        end else if (np == 2) begin
          sd = n;
        end
      end
      if (check_addr && n <= 10) begin
        checkOutput($sformatf("read%0d_rd_en", n - 1), act_bus.act_rd_en, 1);
        checkOutput($sformatf("read%0d_addr", n - 1), act_bus.act_addr, n - 1);
        checkOutput($sformatf("read%0d_busy", n - 1), busy, 1);
      end
      if (check_addr && n == 11) begin
        checkOutput("drain_rd_en", act_bus.act_rd_en, 0);
        checkOutput("drain_addr", act_bus.act_addr, 0);
        checkOutput("drain_busy", busy, 1);
      end
      if (check_addr && n == 13) begin
        checkOutput("after_done_busy", busy, 0);
        checkOutput("after_done_done", done, 0);
      end
      if (abort_at != 0 && n == abort_at + 1) begin
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_rd_en", act_bus.act_rd_en, 0);
        checkOutput("abort_addr", act_bus.act_addr, 0);
      end
      if (reset_at != 0 && n == reset_at + 1) begin
        checkOutput("rst_drain_busy", busy, 0);
        checkOutput("rst_drain_done", done, 0);
        checkOutput("rst_drain_rd_en", act_bus.act_rd_en, 0);
        checkResult("rst_drain", 0, 0, 0);
      end
      if (n == abort_at)   abort = 1'b1;
      if (n == restart_at) start = 1'b1;
      if (n == reset_at)   reset = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      reset = 1'b0;
    end
  endtask

  initial begin
    loadMem(VEC_ZERO);

    // Reset with start and abort also high: reset must win
    reset = 1'b1; start = 1'b1; abort = 1'b1;
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rd_en", act_bus.act_rd_en, 0);
    checkOutput("rst_addr", act_bus.act_addr, 0);
    checkResult("rst", 0, 0, 0);
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    tick();

    loadMem(VEC_A);
    applyStimulus(0, 0, 0, 1'b0, 1'b1, first_done, second_done, pulses, dig_at_done, max_at_done);
    checkOutput("scanA_latency", first_done, 12);
    checkOutput("scanA_pulses", pulses, 1);
    checkOutput("scanA_digit_at_done", dig_at_done, 3);
    checkOutput("scanA_max_at_done", max_at_done, 200);
    checkResult("scanA", 3, 200, 0);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("idle_abort_busy", busy, 0);
    checkResult("idle_abort", 3, 200, 0);

    loadMem(VEC_50);
    applyStimulus(5, 0, 0, 1'b0, 1'b0, first_done, second_done, pulses, dig_at_done, max_at_done);
    checkOutput("abort_pulses", pulses, 0);
    checkResult("abort_hold", 3, 200, 0);

    loadMem(VEC_A);
    applyStimulus(0, 4, 0, 1'b0, 1'b0, first_done, second_done, pulses, dig_at_done, max_at_done);
    checkOutput("restart_latency", first_done, 12);
    checkOutput("restart_pulses", pulses, 1);
    checkResult("restart", 3, 200, 0);

    loadMem(VEC_50);
    applyStimulus(0, 0, 0, 1'b1, 1'b0, first_done, second_done, pulses, dig_at_done, max_at_done);
    checkOutput("ties_latency", first_done, 12);
    checkOutput("ties_pulses", pulses, 1);
    checkResult("ties50", 9, 50, 1);

    loadMem(VEC_A);
    applyStimulus(0, 0, 11, 1'b0, 1'b0, first_done, second_done, pulses, dig_at_done, max_at_done);
    checkOutput("rst_drain_pulses", pulses, 0);
    checkResult("rst_drain_hold", 0, 0, 0);
    applyStimulus(0, 0, 0, 1'b0, 1'b0, first_done, second_done, pulses, dig_at_done, max_at_done);
    checkOutput("post_rst_latency", first_done, 12);
    checkResult("post_rst", 3, 200, 0);

    loadMem(VEC_ZERO);
    applyStimulus(0, 13, 0, 1'b0, 1'b0, first_done, second_done, pulses, dig_at_done, max_at_done);
    checkOutput("b2b_first", first_done, 12);
    checkOutput("b2b_second", second_done, 25);
    checkOutput("b2b_pulses", pulses, 2);
    checkOutput("zeros_digit_at_done", dig_at_done, 9);
    checkResult("zeros", 9, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prediction_sequencer.md
PREDICTION_SEQUENCER -- requirements
Module: prediction_sequencer

Interface
REQ-001 SHALL have parameter NEURON_NUMBER, default 10, number of output-layer activations scanned (2..16).
REQ-002 SHALL have parameter RESOLUTION, default 8, unsigned activation width in bits.
REQ-003 SHALL have parameter THRESHOLD, default 8'd64, minimum winning activation for a confident prediction.
REQ-004 SHALL have port clk, input, 1, the only clock; all logic updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle scan request.
REQ-007 SHALL have port abort, input, 1, cancels an in-progress scan.
REQ-008 SHALL have port act_rd_en, output, 1, activation memory read strobe.
REQ-009 SHALL have port act_addr, output, 4, activation index being read.
REQ-010 SHALL have port act_rdata, input, RESOLUTION, read data, valid exactly 1 cycle after act_rd_en.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when a scan completes.
REQ-013 SHALL have port predicted_digit, output, 4, index of the winning activation.
REQ-014 SHALL have port max_activation, output, RESOLUTION, value of the winning activation.
REQ-015 SHALL have port low_confidence, output, 1, winner below THRESHOLD (present only with PRED_THRESHOLD_EN).

Function
REQ-016 SHALL implement FSM IDLE -> READ -> DRAIN -> DONE -> IDLE.
REQ-017 IDLE: start=1 SHALL move to READ; start while busy SHALL be ignored, not queued.
REQ-018 READ: act_rd_en=1, act_addr=0,1,..,NEURON_NUMBER-1 on consecutive cycles; after last address SHALL go to DRAIN.
REQ-019 DRAIN: act_rd_en=0; captures the final act_rdata; SHALL go to DONE.
REQ-020 Running max SHALL use unsigned compare rdata >= max, so ties resolve to the higher index; running max initialises to 0, index to 0 on scan entry.
REQ-021 DONE: done=1 for exactly one cycle; predicted_digit, max_activation (and low_confidence) SHALL update on the same edge done rises and hold until the next completed scan.
REQ-022 Latency: start sampled at edge t SHALL give done high in cycle t+NEURON_NUMBER+2 (12 cycles for default).
REQ-023 abort in READ or DRAIN SHALL return to IDLE next cycle, drop act_rd_en, no done pulse, outputs unchanged; abort in IDLE/DONE SHALL be ignored.
REQ-024 abort and start in the same IDLE cycle: start SHALL win.
REQ-025 act_addr SHALL hold 0 when act_rd_en=0.

Reset
REQ-026 reset SHALL force IDLE, act_rd_en=0, act_addr=0, busy=0, done=0, predicted_digit=0, max_activation=0, low_confidence=0.
REQ-027 reset SHALL take priority over start and abort; reset mid-scan SHALL discard the partial result.

Configuration
REQ-028 Macro PRED_THRESHOLD_EN defined: low_confidence port exists and equals (max_activation < THRESHOLD), registered with the result.
REQ-029 Macro PRED_THRESHOLD_EN undefined: low_confidence port and compare logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package pred_pkg SHALL hold the FSM state enum, state encoding width and the DIGIT_W=4 constant.
REQ-031 Running-max compare/register SHALL be sub-module argmax_accum (clear, valid, data, idx in; max, max_idx out).

Verification
REQ-032 Activations [3,9,1,200,7,0,5,5,2,100], start -> done at cycle t+12, predicted_digit=3, max_activation=200.
REQ-033 All activations 50 -> predicted_digit=9, max_activation=50; with PRED_THRESHOLD_EN, low_confidence=1.
REQ-034 abort at 5th READ cycle -> busy=0 next cycle, no done, outputs keep prior 3/200.
REQ-035 start pulsed again during READ -> ignored, exactly one done pulse, result unchanged.
REQ-036 reset asserted during DRAIN -> next cycle all outputs 0, IDLE; new start gives a correct full scan.
REQ-037 Activations all 0 -> predicted_digit=9, max_activation=0; back-to-back start on cycle after done -> second scan completes 12 cycles later.
